pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline buffers: fetch/decode, dec_alu, alu/mem and mem/wb.
- Drives per-buffer enable and flush (bubble) controls plus PC update control.
- Resolves load-use stalls, taken-branch flushes, two-cycle 16-bit memory operations (32-bit PC push/pop) and interrupt entry.
- Sits in the core top level beside the decode unit. Its outputs are stable before the negedge capture of the buffers.

Parameters:
- DRAIN_CYCLES, 3: bubble cycles injected before an interrupt push starts. Minimum 1.
- CNT_W, 2: drain counter width. Must hold DRAIN_CYCLES-1.

Ports:
- clk  in  1  clock. State updates on posedge; buffers capture on negedge.
- rst  in  1  asynchronous, active-low reset.
- i_int  in  1  external interrupt request, level.
- i_ex_mem_read  in  1  instruction in dec_alu buffer is a load.
- i_ex_rdst  in  3  destination register of that instruction.
- i_dec_rsrc1, i_dec_rsrc2  in  3 each  source registers of the decoding instruction.
- i_dec_use1, i_dec_use2  in  1 each  the corresponding source is actually read.
- i_branch_taken  in  1  branch resolved taken in the ALU stage.
- i_multi  in  1  instruction in the memory stage needs two 16-bit memory cycles.
- o_pc_en  out  1  PC register enable.
- o_pc_sel  out  2  PC source: 00 sequential, 01 branch target, 10 interrupt vector, 11 unused.
- o_fd_en, o_de_en, o_em_en, o_mw_en  out  1 each  buffer enables.
- o_fd_flush, o_de_flush, o_mw_flush  out  1 each  load a bubble (zero control fields).
- o_mem_phase  out  1  memory half: 0 = high word, 1 = low word.
- o_int_push  out  1  memory stage performs an interrupt push.
- o_int_ack  out  1  one-cycle interrupt acknowledge.
- o_busy  out  1  FSM is not in RUN.

Behaviour:
- States: RUN, MEM2, INT_DRAIN, INT_PUSH_HI, INT_PUSH_LO, INT_VEC.
- Registers: state, ret_state, drain counter, int_pending, int_q (i_int delayed one cycle).
- Outputs are combinational from state and inputs.
- Reset (asynchronous, at any time including mid-sequence):
  - Registers: state=RUN, ret_state=RUN, counter=0, int_pending=0, int_q=0.
  - Resulting outputs: all enables 1, all flushes 0, o_pc_sel=00, o_mem_phase=0, o_int_push=0, o_int_ack=0, o_busy=0.
- int_pending:
  - Set on a rising edge of i_int (i_int=1, int_q=0).
  - Cleared in the cycle o_int_ack=1; clear wins over a simultaneous set.
  - Holding i_int high therefore never causes a second entry.
- Default outputs (no event active) equal the reset values.
- Priority within a cycle: multi > branch > load-use > interrupt entry.
- Multi (RUN or INT_DRAIN, i_multi=1):
  - Cycle N: o_pc_en=o_fd_en=o_de_en=o_em_en=0, o_mw_flush=1, o_mem_phase=0.
  - ret_state <= state; next state MEM2.
  - MEM2: o_mem_phase=1, all enables 1; next state ret_state. Counter holds during both cycles.
  - Any branch or load-use condition present in cycle N is ignored and re-evaluated after MEM2.
- Branch (i_branch_taken=1): o_pc_sel=01, o_pc_en=1, o_fd_flush=1, o_de_flush=1.
- Load-use, lasts exactly one cycle per occurrence:
  - Condition: i_ex_mem_read & ((i_dec_use1 & rsrc1==rdst) | (i_dec_use2 & rsrc2==rdst)).
  - Outputs: o_pc_en=0, o_fd_en=0, o_de_flush=1.
- Interrupt entry: in RUN with int_pending=1 and no multi/branch/load-use, next state INT_DRAIN, counter <= DRAIN_CYCLES-1.
- INT_DRAIN:
  - Base outputs: o_pc_en=0, o_fd_flush=1, other enables 1.
  - Branch here: o_pc_en=1, o_pc_sel=01, flushes as above. The pushed PC is then the branch target.
  - Load-use here: o_de_flush=1; counter holds.
  - Otherwise the counter decrements. At 0 (with no hold) next state INT_PUSH_HI.
- INT_PUSH_HI: o_int_push=1, o_mem_phase=0, o_pc_en=0, o_fd_flush=1. Next state INT_PUSH_LO.
- INT_PUSH_LO: as INT_PUSH_HI but o_mem_phase=1. Next state INT_VEC (or INT_PUSH_FLG when the optional feature is compiled in).
- INT_VEC: o_pc_sel=10, o_pc_en=1, o_int_ack=1, o_fd_flush=1. Next state RUN.
- i_multi and i_branch_taken are ignored in the push and vector states; the pipeline is empty there.

Optional Feature:
- Macro INT_FLAG_SAVE_EN.
- Defined: adds state INT_PUSH_FLG between INT_PUSH_LO and INT_VEC.
  - Outputs: o_int_push=1, o_mem_phase=0, plus extra port o_flag_push=1 (memory writes the CCR).
  - Entry-to-ack latency grows by 1 cycle.
- Undefined: no such state and no o_flag_push port.

Test Plan:
- Load-use: rdst=3, rsrc1=3, use1=1, mem_read=1 -> exactly one cycle o_pc_en=0, o_fd_en=0, o_de_flush=1. Same with use1=0 -> no stall.
- Branch and load-use in the same cycle -> o_pc_sel=01, o_pc_en=1, o_fd_flush=1, o_de_flush=1, o_fd_en=1.
- One-cycle i_multi pulse together with i_branch_taken:
  - Cycle N: all enables 0, o_mw_flush=1, o_mem_phase=0.
  - N+1: o_mem_phase=1.
  - N+2: branch serviced, o_pc_sel=01.
- Interrupt pulse in RUN, DRAIN_CYCLES=3:
  - 3 drain cycles, then HI, LO, VEC.
  - o_int_ack high exactly in cycle 6 after entry; o_busy high for 6 cycles.
- i_int held high for 20 cycles -> a single o_int_ack. Drop i_int, raise again -> second entry.
- Reset asserted during INT_PUSH_LO -> outputs return to reset values immediately. No o_int_ack is seen; int_pending=0 after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline buffer sequencer for load-use stalls, branch flushes, two-cycle memory ops and interrupt entry.
// Optional macro INT_FLAG_SAVE_EN adds a CCR push state and the o_flag_push port.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_int,
  input  logic       i_ex_mem_read,
  input  logic [2:0] i_ex_rdst,
  input  logic [2:0] i_dec_rsrc1,
  input  logic [2:0] i_dec_rsrc2,
  input  logic       i_dec_use1,
  input  logic       i_dec_use2,
  input  logic       i_branch_taken,
  input  logic       i_multi,
  output logic       o_pc_en,
  output logic [1:0] o_pc_sel,
  output logic       o_fd_en,
  output logic       o_de_en,
  output logic       o_em_en,
  output logic       o_mw_en,
  output logic       o_fd_flush,
  output logic       o_de_flush,
  output logic       o_mw_flush,
  output logic       o_mem_phase,
  output logic       o_int_push,
  output logic       o_int_ack,
  output logic       o_busy
`ifdef INT_FLAG_SAVE_EN
  ,
  output logic       o_flag_push
`endif
);
  typedef enum logic [2:0] {
    RUN,
    MEM2,
    INT_DRAIN,
    INT_PUSH_HI,
    INT_PUSH_LO,
    INT_VEC
`ifdef INT_FLAG_SAVE_EN
    ,
    INT_PUSH_FLG
`endif
  } state_t;
  state_t state_q, state_d, ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, int_q;
  logic lu, in_drain, step;
  assign lu = i_ex_mem_read & ((i_dec_use1 & (i_dec_rsrc1 == i_ex_rdst)) |
                               (i_dec_use2 & (i_dec_rsrc2 == i_ex_rdst)));
  assign in_drain = state_q == INT_DRAIN;
  // drain counter advances unless a two-cycle memory op or an unresolved load-use holds it
  assign step = in_drain & ~i_multi & (i_branch_taken | ~lu);
  assign o_busy = state_q != RUN;
  assign pend_d = o_int_ack ? 1'b0 : (i_int & ~int_q) ? 1'b1 : pend_q;
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    o_pc_en     = 1'b1;
    o_pc_sel    = 2'b00;
    o_fd_en     = 1'b1;
    o_de_en     = 1'b1;
    o_em_en     = 1'b1;
    o_mw_en     = 1'b1;
    o_fd_flush  = 1'b0;
    o_de_flush  = 1'b0;
    o_mw_flush  = 1'b0;
    o_mem_phase = 1'b0;
    o_int_push  = 1'b0;
    o_int_ack   = 1'b0;
`ifdef INT_FLAG_SAVE_EN
    o_flag_push = 1'b0;
`endif
    case (state_q)
      RUN, INT_DRAIN: begin
        o_pc_en    = ~in_drain;
        o_fd_flush = in_drain;
        if (i_multi) begin
          o_pc_en    = 1'b0;
          o_fd_en    = 1'b0;
          o_de_en    = 1'b0;
          o_em_en    = 1'b0;
          o_fd_flush = 1'b0;
          o_mw_flush = 1'b1;
          ret_d      = state_q;
          state_d    = MEM2;
        end else if (i_branch_taken) begin
          o_pc_en    = 1'b1;
          o_pc_sel   = 2'b01;
          o_fd_flush = 1'b1;
          o_de_flush = 1'b1;
        end else if (lu) begin
          o_pc_en    = 1'b0;
          o_fd_en    = in_drain;
          o_de_flush = 1'b1;
        end else if (!in_drain && pend_q) begin
          state_d = INT_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
        if (step) begin
          if (cnt_q == '0) state_d = INT_PUSH_HI;
          else cnt_d = cnt_q - 1'b1;
        end
      end
      MEM2: begin
        o_mem_phase = 1'b1;
        state_d     = ret_q;
      end
      INT_PUSH_HI: begin
        o_int_push = 1'b1;
        o_pc_en    = 1'b0;
        o_fd_flush = 1'b1;
        state_d    = INT_PUSH_LO;
      end
      INT_PUSH_LO: begin
        o_int_push  = 1'b1;
        o_mem_phase = 1'b1;
        o_pc_en     = 1'b0;
        o_fd_flush  = 1'b1;
`ifdef INT_FLAG_SAVE_EN
        state_d     = INT_PUSH_FLG;
`else
        state_d     = INT_VEC;
`endif
      end
`ifdef INT_FLAG_SAVE_EN
      INT_PUSH_FLG: begin
        o_int_push  = 1'b1;
        o_flag_push = 1'b1;
        o_pc_en     = 1'b0;
        o_fd_flush  = 1'b1;
        state_d     = INT_VEC;
      end
`endif
      INT_VEC: begin
        o_pc_sel   = 2'b10;
        o_int_ack  = 1'b1;
        o_fd_flush = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      int_q   <= i_int;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stalls, flushes, two-cycle memory ops and interrupt entry.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic i_int = 1'b0, mr = 1'b0, u1 = 1'b0, u2 = 1'b0, br = 1'b0, multi = 1'b0;
  logic [2:0] rd = '0, r1 = '0, r2 = '0;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, mw_fl, ph, push, ack, busy;
  logic [1:0] pc_sel;
  logic [13:0] outs;
  int total = 0, bad = 0;
`ifdef INT_FLAG_SAVE_EN
  logic flag_push;
`endif
  always #5 clk = ~clk;
  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .i_int(i_int), .i_ex_mem_read(mr), .i_ex_rdst(rd),
    .i_dec_rsrc1(r1), .i_dec_rsrc2(r2), .i_dec_use1(u1), .i_dec_use2(u2),
    .i_branch_taken(br), .i_multi(multi), .o_pc_en(pc_en), .o_pc_sel(pc_sel),
    .o_fd_en(fd_en), .o_de_en(de_en), .o_em_en(em_en), .o_mw_en(mw_en),
    .o_fd_flush(fd_fl), .o_de_flush(de_fl), .o_mw_flush(mw_fl), .o_mem_phase(ph),
    .o_int_push(push), .o_int_ack(ack), .o_busy(busy)
`ifdef INT_FLAG_SAVE_EN
    , .o_flag_push(flag_push)
`endif
  );
  // {pc_en, pc_sel, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, mem_phase, int_push, int_ack, busy}
  assign outs = {pc_en, pc_sel, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, mw_fl, ph, push, ack, busy};
  localparam logic [13:0] DEF  = 14'b1_00_1111_000_0000;
  localparam logic [13:0] LU   = 14'b0_00_0111_010_0000;
  localparam logic [13:0] BR   = 14'b1_01_1111_110_0000;
  localparam logic [13:0] MUL  = 14'b0_00_0001_001_0000;
  localparam logic [13:0] MEM2 = 14'b1_00_1111_000_1001;
  localparam logic [13:0] DR   = 14'b0_00_1111_100_0001;
  localparam logic [13:0] DRLU = 14'b0_00_1111_110_0001;
  localparam logic [13:0] DRBR = 14'b1_01_1111_110_0001;
  localparam logic [13:0] PHI  = 14'b0_00_1111_100_0101;
  localparam logic [13:0] PLO  = 14'b0_00_1111_100_1101;
  localparam logic [13:0] VEC  = 14'b1_10_1111_100_0011;
  typedef struct {
    logic mr, u1, u2, br;
    logic [2:0] rd, r1, r2;
    logic [13:0] exp;
  } vec_t;
  vec_t tv[8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input logic [13:0] e, input string n);
    #1;
    total++;
    if (outs !== e) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", n, outs, e, $time);
    end
  endtask
  task automatic chk_int(input int got, input int e, input string n);
    total++;
    if (got != e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, e);
    end
  endtask
  int acks, busy_n, found;
  initial begin
    tv[0] = '{mr:1, u1:1, u2:0, br:0, rd:3, r1:3, r2:0, exp:LU};
    tv[1] = '{mr:1, u1:0, u2:1, br:0, rd:3, r1:3, r2:5, exp:DEF};
    tv[2] = '{mr:1, u1:1, u2:1, br:0, rd:3, r1:0, r2:3, exp:LU};
    tv[3] = '{mr:0, u1:1, u2:0, br:0, rd:3, r1:3, r2:0, exp:DEF};
    tv[4] = '{mr:1, u1:1, u2:0, br:1, rd:3, r1:3, r2:0, exp:BR};
    tv[5] = '{mr:0, u1:0, u2:0, br:1, rd:0, r1:0, r2:0, exp:BR};
    tv[6] = '{mr:1, u1:1, u2:1, br:0, rd:7, r1:6, r2:7, exp:LU};
    tv[7] = '{mr:0, u1:0, u2:0, br:0, rd:0, r1:0, r2:0, exp:DEF};
    #2;
    chk(DEF, "reset_state");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk(DEF, "idle");
    for (int i = 0; i < 8; i++) begin
      tick();
      {mr, u1, u2, br, rd, r1, r2} = {tv[i].mr, tv[i].u1, tv[i].u2, tv[i].br, tv[i].rd, tv[i].r1, tv[i].r2};
      chk(tv[i].exp, $sformatf("vec%0d", i));
    end
    // multi with a simultaneous branch: branch waits until after MEM2
    tick(); multi = 1'b1; br = 1'b1; chk(MUL, "multi_n");
    tick(); multi = 1'b0; chk(MEM2, "multi_n1");
    tick(); chk(BR, "multi_n2_branch");
    tick(); br = 1'b0; chk(DEF, "after_multi");
    // interrupt pulse: 3 drain, HI, LO, VEC
    tick(); i_int = 1'b1; chk(DEF, "int_raise");
    tick(); i_int = 1'b0; chk(DEF, "int_entry");
    acks = 0; busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk(i < 3 ? DR : i == 3 ? PHI : i == 4 ? PLO : i == 5 ? VEC : DEF, $sformatf("int_seq%0d", i));
      if (ack) begin
        chk_int(i + 1, 6, "ack_cycle");
        acks++;
      end
      busy_n += busy;
    end
    chk_int(acks, 1, "ack_count");
    chk_int(busy_n, 6, "busy_cycles");
    // drain with load-use (holds counter) and branch (counts)
    tick(); i_int = 1'b1; chk(DEF, "int2_raise");
    tick(); i_int = 1'b0; chk(DEF, "int2_entry");
    tick(); {mr, u1, rd, r1} = {1'b1, 1'b1, 3'd2, 3'd2}; chk(DRLU, "drain_lu");
    tick(); {mr, u1} = 2'b00; chk(DR, "drain_held");
    tick(); br = 1'b1; chk(DRBR, "drain_branch");
    tick(); br = 1'b0; chk(DR, "drain_last");
    tick(); chk(PHI, "int2_hi");
    tick(); chk(PLO, "int2_lo");
    tick(); chk(VEC, "int2_vec");
    tick(); chk(DEF, "int2_done");
    // level held high: exactly one entry, then a new rising edge gives another
    acks = 0;
    i_int = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); #1 acks += ack; end
    i_int = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); #1 acks += ack; end
    chk_int(acks, 1, "held_single_ack");
    acks = 0;
    tick(); i_int = 1'b1;
    tick(); i_int = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); #1 acks += ack; end
    chk_int(acks, 1, "reraise_ack");
    // reset during INT_PUSH_LO
    tick(); i_int = 1'b1;
    tick(); i_int = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      #1 if (push && ph) found = 1;
    end
    chk_int(found, 1, "reach_push_lo");
    rst = 1'b0;
    chk(DEF, "reset_mid_push");
    tick(); rst = 1'b1;
    acks = 0; busy_n = 0;
    for (int i = 0; i < 15; i++) begin tick(); #1 acks += ack; busy_n += busy; end
    chk_int(acks, 0, "no_ack_after_reset");
    chk_int(busy_n, 0, "idle_after_reset");
    chk(DEF, "final_default");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
